// File: rtl/tx_rc_shaper.sv
// Transmit pulse shaper: maps one BPSK bit per symbol to +/-1 and emits OS
// raised-cosine samples per symbol through a polyphase FIR with saturation.
module tx_rc_shaper #(
  parameter int OS     = 4,
  parameter int TAPS   = 6,
  parameter int S_COEF = 8,
  parameter int S_IN   = 2,
  parameter int S_OUT  = S_COEF + S_IN,
  parameter logic [OS*TAPS*S_COEF-1:0] COEF =
    (OS*TAPS*S_COEF)'(127) << ((TAPS/2)*OS*S_COEF)
) (
  input  logic                    clock,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_valid,
  input  logic                    i_bit,
  output logic                    o_bit_ready,
  output logic signed [S_OUT-1:0] o_rc_filter,
  output logic                    o_valid,
  output logic                    o_sym_strobe,
  output logic [$clog2(OS)-1:0]   o_phase
);

  localparam int PW    = $clog2(OS);
  localparam int P_W   = S_COEF + S_IN;
  localparam int ACC_W = S_COEF + S_IN + $clog2(TAPS);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2**(S_OUT-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
  localparam logic [PW-1:0] PH_LAST = PW'(OS - 1);

  // Handshake: the input side has no ready/valid pair of its own; a bit is
  // taken exactly when o_bit_ready is high, and the output has no back-pressure.

  logic [PW-1:0]           phase;
  logic signed [S_IN-1:0]  sym      [TAPS];
  logic signed [S_IN-1:0]  sym_next [TAPS];
  logic signed [S_COEF-1:0] coef_tab [TAPS][OS];
  logic signed [S_IN-1:0]  sym_in;
  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [S_OUT-1:0] sat_val;
  logic                    adv;

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    for (genvar p = 0; p < OS; p++) begin : g_ph
      assign coef_tab[k][p] = COEF[(k*OS+p)*S_COEF +: S_COEF];
    end
  end

  assign adv         = i_enable & i_valid;
  assign o_bit_ready = adv & (phase == '0);
  assign o_phase     = phase;
  assign sym_in      = i_bit ? {S_IN{1'b1}} : S_IN'(1);

  // The shift register update and the sample it produces share one edge, so
  // the FIR works on the post-shift contents.
  always_comb begin
    for (int k = 0; k < TAPS; k++) sym_next[k] = sym[k];
    if (phase == '0) begin
      sym_next[0] = sym_in;
      for (int k = 1; k < TAPS; k++) sym_next[k] = sym[k-1];
    end
  end

  always_comb begin
    acc  = '0;
    prod = '0;
    for (int k = 0; k < TAPS; k++) begin
      prod = P_W'(sym_next[k]) * P_W'(coef_tab[k][phase]);
      acc  = acc + ACC_W'(prod);
    end
    if (acc > SAT_HI)      sat_val = S_OUT'(SAT_HI);
    else if (acc < SAT_LO) sat_val = S_OUT'(SAT_LO);
    else                   sat_val = S_OUT'(acc);
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      phase        <= '0;
      o_rc_filter  <= '0;
      o_valid      <= 1'b0;
      o_sym_strobe <= 1'b0;
      for (int k = 0; k < TAPS; k++) sym[k] <= '0;
    end else begin
      o_valid      <= adv;
      o_sym_strobe <= adv & (phase == '0);
      if (adv) begin
        phase       <= (phase == PH_LAST) ? '0 : phase + 1'b1;
        o_rc_filter <= sat_val;
        for (int k = 0; k < TAPS; k++) sym[k] <= sym_next[k];
      end
    end
  end

endmodule

// File: tb/tb_tx_rc_shaper.sv
// Directed bench for tx_rc_shaper: three instances (delta, coef[0]-only and
// all-127 tables) share one stimulus stream; each task checks its scenario.
module tb_tx_rc_shaper;

  logic clock = 1'b0;
  logic i_reset, i_enable, i_valid, i_bit;

  logic br_d, v_d, ss_d, br_z, v_z, ss_z, br_a, v_a, ss_a;
  logic signed [9:0] rc_d, rc_z, rc_a;
  logic [1:0] ph_d, ph_z, ph_a;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  tx_rc_shaper dut_d (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_bit(i_bit), .o_bit_ready(br_d), .o_rc_filter(rc_d), .o_valid(v_d),
    .o_sym_strobe(ss_d), .o_phase(ph_d));

  tx_rc_shaper #(.COEF(192'(64))) dut_z (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_bit(i_bit), .o_bit_ready(br_z), .o_rc_filter(rc_z), .o_valid(v_z),
    .o_sym_strobe(ss_z), .o_phase(ph_z));

  tx_rc_shaper #(.COEF({24{8'd127}})) dut_a (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_bit(i_bit), .o_bit_ready(br_a), .o_rc_filter(rc_a), .o_valid(v_a),
    .o_sym_strobe(ss_a), .o_phase(ph_a));

  task automatic drive(input logic en, input logic val, input logic b);
    i_enable = en;
    i_valid  = val;
    i_bit    = b;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    drive(0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    i_reset = 1'b1;
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    drive(0, 0, 0);
    #1;
    n_checks++; if (rc_d !== 10'sd0 || rc_z !== 10'sd0 || rc_a !== 10'sd0) begin
      n_fail++; $display("FAIL reset_rc got %0d/%0d/%0d exp 0", rc_d, rc_z, rc_a); end
    n_checks++; if ({v_d, v_z, v_a, ss_d, ss_z, ss_a} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags got %b exp 000000", {v_d, v_z, v_a, ss_d, ss_z, ss_a}); end
    n_checks++; if (ph_a !== 2'd0 || br_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_phase got ph=%0d br=%b exp 0/0", ph_a, br_a); end
  endtask

  task automatic test_delta();
    int exp1 [6] = '{0, 0, 0, 127, -127, 127};
    logic bits1 [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic signed [9:0] e;
    do_reset();
    for (int s = 0; s < 6; s++) begin
      for (int p = 0; p < 4; p++) begin
        drive(1, 1, bits1[s]);
        #1;
        n_checks++; if (br_d !== (p == 0)) begin
          n_fail++; $display("FAIL delta_ready s=%0d p=%0d got %b exp %b", s, p, br_d, p == 0); end
        tick();
        e = (p == 0) ? 10'(exp1[s]) : 10'sd0;
        n_checks++; if (rc_d !== e) begin
          n_fail++; $display("FAIL delta_rc s=%0d p=%0d got %0d exp %0d", s, p, rc_d, e); end
        n_checks++; if (v_d !== 1'b1 || ss_d !== (p == 0)) begin
          n_fail++; $display("FAIL delta_strobe s=%0d p=%0d got v=%b ss=%b exp 1/%b", s, p, v_d, ss_d, p == 0); end
        n_checks++; if (ph_d !== 2'((p + 1) % 4)) begin
          n_fail++; $display("FAIL delta_phase s=%0d p=%0d got %0d exp %0d", s, p, ph_d, (p + 1) % 4); end
      end
    end
  endtask

  task automatic test_latency();
    logic signed [9:0] e;
    do_reset();
    for (int s = 0; s < 2; s++) begin
      for (int p = 0; p < 4; p++) begin
        drive(1, 1, s[0]);
        tick();
        e = (p != 0) ? 10'sd0 : (s == 0) ? 10'sd64 : -10'sd64;
        n_checks++; if (rc_z !== e) begin
          n_fail++; $display("FAIL latency_rc s=%0d p=%0d got %0d exp %0d", s, p, rc_z, e); end
      end
    end
  endtask

  task automatic test_saturation();
    int exp3 [12] = '{127, 254, 381, 508, 511, 511, 508, 254, 0, -254, -508, -512};
    logic signed [9:0] e;
    do_reset();
    for (int s = 0; s < 12; s++) begin
      for (int p = 0; p < 4; p++) begin
        drive(1, 1, s >= 6);
        tick();
        e = 10'(exp3[s]);
        n_checks++; if (rc_a !== e) begin
          n_fail++; $display("FAIL sat_rc s=%0d p=%0d got %0d exp %0d", s, p, rc_a, e); end
      end
    end
  endtask

  task automatic test_valid_toggle();
    logic signed [9:0] e = 10'sd0;
    logic [1:0] ph = 2'd0;
    logic val, b, was_p0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      val = (c % 2 == 0);
      b   = (c < 8);
      drive(1, val, b);
      #1;
      n_checks++; if (br_z !== (val && ph == 2'd0)) begin
        n_fail++; $display("FAIL toggle_ready c=%0d got %b exp %b", c, br_z, val && ph == 2'd0); end
      was_p0 = (ph == 2'd0);
      if (val) begin
        e  = !was_p0 ? 10'sd0 : b ? -10'sd64 : 10'sd64;
        ph = ph + 2'd1;
      end
      tick();
      n_checks++; if (v_z !== val || ss_z !== (val && was_p0)) begin
        n_fail++; $display("FAIL toggle_strobe c=%0d got v=%b ss=%b exp %b/%b", c, v_z, ss_z, val, val && was_p0); end
      n_checks++; if (ph_z !== ph || rc_z !== e) begin
        n_fail++; $display("FAIL toggle_data c=%0d got ph=%0d rc=%0d exp %0d/%0d", c, ph_z, rc_z, ph, e); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (2) begin drive(1, 1, 1); tick(); end
    n_checks++; if (ph_a !== 2'd2 || rc_a !== -10'sd127) begin
      n_fail++; $display("FAIL stall_pre got ph=%0d rc=%0d exp 2/-127", ph_a, rc_a); end
    for (int c = 0; c < 5; c++) begin
      drive(0, 1, c[0]);
      #1;
      n_checks++; if (br_a !== 1'b0) begin
        n_fail++; $display("FAIL stall_ready c=%0d got %b exp 0", c, br_a); end
      tick();
      n_checks++; if (v_a !== 1'b0 || ss_a !== 1'b0 || ph_a !== 2'd2 || rc_a !== -10'sd127) begin
        n_fail++; $display("FAIL stall_hold c=%0d got v=%b ss=%b ph=%0d rc=%0d exp 0/0/2/-127", c, v_a, ss_a, ph_a, rc_a); end
    end
    drive(1, 1, 0); tick();
    n_checks++; if (v_a !== 1'b1 || ss_a !== 1'b0 || ph_a !== 2'd3 || rc_a !== -10'sd127) begin
      n_fail++; $display("FAIL stall_resume got v=%b ss=%b ph=%0d rc=%0d exp 1/0/3/-127", v_a, ss_a, ph_a, rc_a); end
    drive(1, 1, 0); tick();
    drive(1, 1, 0); tick();
    n_checks++; if (ss_a !== 1'b1 || rc_a !== 10'sd0 || rc_z !== 10'sd64 || ph_a !== 2'd1) begin
      n_fail++; $display("FAIL stall_next got ss=%b rc_a=%0d rc_z=%0d ph=%0d exp 1/0/64/1", ss_a, rc_a, rc_z, ph_a); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (18) begin drive(1, 1, 0); tick(); end
    n_checks++; if (ph_a !== 2'd2 || rc_a !== 10'sd511 || v_a !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pre got ph=%0d rc=%0d v=%b exp 2/511/1", ph_a, rc_a, v_a); end
    #2;
    i_reset = 1'b0;
    #1;
    n_checks++; if (rc_a !== 10'sd0 || rc_z !== 10'sd0 || v_a !== 1'b0 || ph_a !== 2'd0) begin
      n_fail++; $display("FAIL rmid_async got rc_a=%0d rc_z=%0d v=%b ph=%0d exp 0/0/0/0", rc_a, rc_z, v_a, ph_a); end
    drive(0, 0, 0);
    tick();
    i_reset = 1'b1;
    drive(1, 1, 1);
    #1;
    n_checks++; if (br_a !== 1'b1) begin
      n_fail++; $display("FAIL rmid_ready got %b exp 1", br_a); end
    tick();
    n_checks++; if (ss_a !== 1'b1 || v_a !== 1'b1) begin
      n_fail++; $display("FAIL rmid_strobe got v=%b ss=%b exp 1/1", v_a, ss_a); end
    n_checks++; if (rc_a !== -10'sd127 || rc_z !== -10'sd64 || rc_d !== 10'sd0) begin
      n_fail++; $display("FAIL rmid_data got %0d/%0d/%0d exp -127/-64/0", rc_a, rc_z, rc_d); end
  endtask

  initial begin
    test_reset();
    test_delta();
    test_latency();
    test_saturation();
    test_valid_toggle();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_rc_shaper.md
Name: tx_rc_shaper

Overview:
Transmit-side pulse shaper: accepts one BPSK bit per symbol period, maps it to ±1 and produces OS raised-cosine samples per symbol with a polyphase FIR. It drives the S_OUT-wide sample stream that the receive-side symbol synchronizer consumes (i_rc_filter), so both ends share OS, TAPS, S_COEF, S_IN and S_OUT. It sits between the bit source (PRBS or file) and the channel/receive chain.

Parameters:
OS, 4, oversampling factor (samples per symbol), ≥2
TAPS, 6, FIR span in symbols (symbols held in shift register)
S_COEF, 8, coefficient width, signed two's complement
S_IN, 2, mapped-symbol width, signed (+1 = 2'b01, -1 = 2'b11, 0 = 2'b00)
S_OUT, S_COEF+S_IN, output sample width, signed
COEF, delta, flattened table of OS*TAPS coefficients; coef m = k*OS+p at bits [m*S_COEF +: S_COEF]; default coef[(TAPS/2)*OS] = 127, all others 0

Ports:
clock  in  1  system clock, rising edge
i_reset  in  1  asynchronous reset, active-low
i_enable  in  1  global enable; low freezes all state
i_valid  in  1  sample-rate strobe; one output sample per cycle with i_enable&i_valid
i_bit  in  1  next data bit; 0 -> +1, 1 -> -1; sampled only when o_bit_ready=1
o_bit_ready  out  1  combinational: i_enable & i_valid & (phase==0); bit consumed this cycle
o_rc_filter  out  S_OUT  signed shaped sample, registered
o_valid  out  1  registered; high for one cycle per produced sample
o_sym_strobe  out  1  registered; high with o_valid when the sample is phase 0 (symbol instant)

Behaviour:
- Reset (i_reset=0, async): phase=0, shift register sym[0..TAPS-1]=0 (zero symbols), o_rc_filter=0, o_valid=0, o_sym_strobe=0. Release synchronous to next edge; first accepted cycle is phase 0.
- Advance condition adv = i_enable & i_valid. adv=0: phase, shift register, o_rc_filter held; o_valid=0, o_sym_strobe=0.
- Phase counter 0..OS-1, increments on adv, wraps OS-1 -> 0.
- On adv edge with phase p: if p==0, sym' = {map(i_bit), sym[0..TAPS-2]} (sym[0] newest), else sym' = sym. Register sym <= sym'.
- Same edge: o_rc_filter <= sat(Σ_{k=0..TAPS-1} sym'[k] * coef[k*OS+p]); o_valid <= 1; o_sym_strobe <= (p==0). Latency: bit presented at phase-0 cycle affects the sample registered on that same edge (1 cycle to output).
- Arithmetic: products signed S_COEF+S_IN bits; accumulator S_COEF+S_IN+ceil(log2 TAPS) bits, no intermediate truncation; result clamped to [-2^(S_OUT-1), 2^(S_OUT-1)-1] (default [-512, 511]).
- i_bit ignored when o_bit_ready=0; no back-pressure on output.
- i_enable low mid-symbol: phase preserved; resumes at next phase, no sample skipped or repeated.
- Reset mid-symbol: immediate clear; partially emitted symbol discarded.

Test Plan:
1. Default COEF, reset, adv every cycle, bits 0,1,0 -> o_rc_filter 0 until symbol 3 (k=3) reaches its tap: then +127 at phase 0 only, zeros at phases 1-3, then -127, then +127 on successive symbol instants; o_sym_strobe every 4th o_valid.
2. COEF coef[0]=64 only, bits 0,1 -> sample +64 on the same edge as bit 0's o_bit_ready cycle, three zeros, then -64; verifies 1-cycle latency and k=0/p=0 indexing.
3. All coefs 127, six bits 0 -> after 6th symbol output 762 clamped to 511; six bits 1 -> -762 clamped to -512.
4. i_valid toggled 1,0,1,0... -> one sample per valid cycle, o_valid mirrors delayed strobe, phase sequence 0,1,2,3 unbroken, o_bit_ready only on phase-0 valid cycles.
5. i_enable dropped for 5 cycles at phase 2 -> o_rc_filter held, o_valid=0, resumes at phase 3; i_bit changes during stall ignored.
6. Assert i_reset low at phase 2 of symbol 4 -> outputs 0 immediately (async), after release first o_valid sample has o_sym_strobe=1 and reflects only the newly consumed bit.
